// File: rtl/key_hex_display.sv
// Seven-segment status display for the key-search datapath: blank when idle,
// a blinking dash row while searching, the hex key when found, and steady dashes when not found.
module key_hex_display #(
  parameter int KEY_W      = 24,
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    done,
  input  logic                    key_valid,
  input  logic [KEY_W-1:0]        key,
  input  logic                    clear,
  output logic [NUM_DIGITS*7-1:0] hex,
  output logic                    busy
);

  localparam int USED_DIGITS = (KEY_W + 3) / 4;
  localparam int EXT_W       = NUM_DIGITS * 4;
  localparam int CNT_W       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_FOUND,
    ST_FAIL
  } state_t;

  state_t                  r_state, w_state_next;
  logic [KEY_W-1:0]        r_key, w_key_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_next;
  logic                    r_phase, w_phase_next;
  logic [NUM_DIGITS*7-1:0] r_hex, w_hex_next;
  logic                    r_busy, w_busy_next;
  logic [EXT_W-1:0]        w_key_ext;

  function automatic logic [6:0] f_glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    f_glyph = 7'b1000000;
      4'h1:    f_glyph = 7'b1111001;
      4'h2:    f_glyph = 7'b0100100;
      4'h3:    f_glyph = 7'b0110000;
      4'h4:    f_glyph = 7'b0011001;
      4'h5:    f_glyph = 7'b0010010;
      4'h6:    f_glyph = 7'b0000010;
      4'h7:    f_glyph = 7'b1111000;
      4'h8:    f_glyph = 7'b0000000;
      4'h9:    f_glyph = 7'b0010000;
      4'hA:    f_glyph = 7'b0001000;
      4'hB:    f_glyph = 7'b0000011;
      4'hC:    f_glyph = 7'b1000110;
      4'hD:    f_glyph = 7'b0100001;
      4'hE:    f_glyph = 7'b0000110;
      default: f_glyph = 7'b0001110;
    endcase
  endfunction

  // Priority clear > start > done; done is only honoured while searching.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    w_state_next = r_state;
    w_key_next   = r_key;
    w_cnt_next   = '0;
    w_phase_next = r_phase;
    if (clear) begin
      w_state_next = ST_IDLE;
    end else if (start) begin
      w_state_next = ST_SEARCH;
      w_phase_next = 1'b1;
    end else if (r_state == ST_SEARCH) begin
      if (done) begin
        w_state_next = key_valid ? ST_FOUND : ST_FAIL;
        if (key_valid) w_key_next = key;
      end else if (r_cnt == CNT_LAST) begin
        w_phase_next = ~r_phase;
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end
  end

  // Display is decoded from the next state so it lands on the same edge as the state change.
  assign w_key_ext = EXT_W'(w_key_next);

  always_comb begin
    w_hex_next = {(NUM_DIGITS * 7){1'b1}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i < USED_DIGITS) begin
        case (w_state_next)
          ST_SEARCH: w_hex_next[7*i +: 7] = w_phase_next ? SEG_DASH : SEG_BLANK;
          ST_FOUND:  w_hex_next[7*i +: 7] = f_glyph(w_key_ext[4*i +: 4]);
          ST_FAIL:   w_hex_next[7*i +: 7] = SEG_DASH;
          default:   w_hex_next[7*i +: 7] = SEG_BLANK;
        endcase
      end
    end
    w_busy_next = (w_state_next == ST_SEARCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_key   <= '0;
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_hex   <= {(NUM_DIGITS * 7){1'b1}};
      r_busy  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_next;
      r_key   <= w_key_next;
      r_cnt   <= w_cnt_next;
      r_phase <= w_phase_next;
      r_hex   <= w_hex_next;
      r_busy  <= w_busy_next;
    end
  end

  assign hex  = r_hex;
  assign busy = r_busy;

endmodule

// File: tb/tb_key_hex_display.sv
// Bench for key_hex_display: a wide (24-bit key, 6 digits) and a narrow (10-bit key, 4 digits)
// instance share one control stream and are compared each cycle against a mode-level model.
module tb_key_hex_display;

  localparam int BLINK = 4;
  localparam int M_IDLE = 0, M_SEARCH = 1, M_FOUND = 2, M_FAIL = 3;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, done = 1'b0, key_valid = 1'b0, clear = 1'b0;
  logic [23:0] key_a = '0;
  logic [9:0]  key_b;
  logic [41:0] hex_a;
  logic [27:0] hex_b;
  logic        busy_a, busy_b;

  assign key_b = key_a[9:0];

  key_hex_display #(.KEY_W(24), .NUM_DIGITS(6), .BLINK_DIV(BLINK)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .key_valid(key_valid),
    .key(key_a), .clear(clear), .hex(hex_a), .busy(busy_a));

  key_hex_display #(.KEY_W(10), .NUM_DIGITS(4), .BLINK_DIV(BLINK)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .key_valid(key_valid),
    .key(key_b), .clear(clear), .hex(hex_b), .busy(busy_b));

  always #5 clk = ~clk;

  // Model: display mode, cycles elapsed since the last start, and the key each instance latched.
  int          m_mode = M_IDLE;
  int          m_cyc = 0;
  logic [23:0] m_key_a = '0;
  logic [9:0]  m_key_b = '0;
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic logic [6:0] f_digit(input int i, input int used, input logic [23:0] k);
    logic [23:0] sh;
    logic [3:0]  nib;
    sh  = k >> (4 * i);
    nib = sh[3:0];
    if (i >= used) return 7'b1111111;
    case (m_mode)
      M_SEARCH: return (((m_cyc / BLINK) % 2) == 0) ? 7'b0111111 : 7'b1111111;
      M_FOUND:  return GLYPH[nib];
      M_FAIL:   return 7'b0111111;
      default:  return 7'b1111111;
    endcase
  endfunction

  // Layout {busy_b, busy_a, hex_b, hex_a}.
  function automatic logic [71:0] f_expect();
    logic [71:0] e;
    e = '1;
    for (int i = 0; i < 6; i++) e[7*i +: 7] = f_digit(i, 6, m_key_a);
    for (int i = 0; i < 4; i++) e[42 + 7*i +: 7] = f_digit(i, 3, {14'b0, m_key_b});
    e[70] = (m_mode == M_SEARCH);
    e[71] = (m_mode == M_SEARCH);
    return e;
  endfunction

  task automatic cycle(input logic st, input logic dn, input logic kv, input logic clr,
                       input logic [23:0] k);
    start = st; done = dn; key_valid = kv; clear = clr; key_a = k;
    @(posedge clk);
    if (clr) begin
      m_mode = M_IDLE;
    end else if (st) begin
      m_mode = M_SEARCH;
      m_cyc  = 0;
    end else if (m_mode == M_SEARCH && dn) begin
      m_mode = kv ? M_FOUND : M_FAIL;
      if (kv) begin
        m_key_a = k;
        m_key_b = k[9:0];
      end
    end else if (m_mode == M_SEARCH) begin
      m_cyc++;
    end
    #1;
    start = 1'b0; done = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    n_chk++;
    if ({busy_b, busy_a, hex_b, hex_a} !== f_expect()) begin
      $display("FAIL reset_hold got=%h want=%h", {busy_b, busy_a, hex_b, hex_a}, f_expect());
    end else n_pass++;
    rst_n = 1'b1;
    repeat (2) cycle(0, 0, 0, 0, 24'h0);
    cycle(1, 0, 0, 0, 24'h0);
    cycle(0, 0, 0, 0, 24'h0);
    #2 rst_n = 1'b0;
    m_mode = M_IDLE;
    #1;
    n_chk++;
    if ({busy_b, busy_a, hex_b, hex_a} !== {2'b00, 70'h3f_ffff_ffff_ffff_ffff}) begin
      $display("FAIL reset_async got=%h want=all-blank", {busy_b, busy_a, hex_b, hex_a});
    end else n_pass++;
    #2 rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cycle(0, n == 1, 1, 0, 24'h123456);
      n_chk++;
      if ({busy_b, busy_a, hex_b, hex_a} !== f_expect()) begin
        $display("FAIL reset_after n=%0d got=%h want=%h", n, {busy_b, busy_a, hex_b, hex_a}, f_expect());
      end else n_pass++;
    end
  endtask

  task automatic test_blink();
    cycle(1, 0, 0, 0, 24'h0);
    n_chk++;
    if (busy_a !== 1'b1 || hex_a[6:0] !== 7'b0111111) begin
      $display("FAIL blink_first busy=%b dig0=%b want busy=1 dig0=0111111", busy_a, hex_a[6:0]);
    end else n_pass++;
    for (int n = 1; n <= 20; n++) begin
      cycle(0, 0, 0, 0, 24'h0);
      n_chk++;
      if ({busy_b, busy_a, hex_b, hex_a} !== f_expect()) begin
        $display("FAIL blink n=%0d got=%h want=%h", n, {busy_b, busy_a, hex_b, hex_a}, f_expect());
      end else n_pass++;
    end
  endtask

  task automatic test_found();
    cycle(1, 0, 0, 0, 24'h0);
    cycle(0, 0, 0, 0, 24'h0);
    cycle(0, 1, 1, 0, 24'h03A5F1);
    n_chk++;
    if (hex_a !== {GLYPH[0], GLYPH[3], GLYPH[10], GLYPH[5], GLYPH[15], GLYPH[1]} || busy_a !== 1'b0) begin
      $display("FAIL found_03A5F1 got=%h busy=%b want=%h busy=0", hex_a, busy_a,
               {GLYPH[0], GLYPH[3], GLYPH[10], GLYPH[5], GLYPH[15], GLYPH[1]});
    end else n_pass++;
    for (int n = 0; n < 5; n++) begin
      cycle(0, 0, $urandom_range(0, 1), 0, 24'($urandom));
      n_chk++;
      if ({busy_b, busy_a, hex_b, hex_a} !== f_expect()) begin
        $display("FAIL found_hold n=%0d got=%h want=%h", n, {busy_b, busy_a, hex_b, hex_a}, f_expect());
      end else n_pass++;
    end
  endtask

  task automatic test_not_found();
    cycle(1, 0, 0, 0, 24'h0);
    cycle(0, 1, 0, 0, 24'hFFFFFF);
    for (int n = 0; n < 3 * BLINK + 2; n++) begin
      cycle(0, 0, 0, 0, 24'($urandom));
      n_chk++;
      if ({busy_b, busy_a, hex_b, hex_a} !== f_expect() || hex_a !== {6{7'b0111111}}) begin
        $display("FAIL not_found n=%0d got=%h want=%h", n, {busy_b, busy_a, hex_b, hex_a}, f_expect());
      end else n_pass++;
    end
  endtask

  task automatic test_priority();
    logic [4:0] seq [8];
    seq = '{5'b00001, 5'b01100, 5'b11100, 5'b10001, 5'b01100, 5'b10000, 5'b01000, 5'b11101};
    for (int n = 0; n < 8; n++) begin
      cycle(seq[n][4], seq[n][3], seq[n][2], seq[n][0], 24'($urandom));
      n_chk++;
      if ({busy_b, busy_a, hex_b, hex_a} !== f_expect()) begin
        $display("FAIL priority n=%0d got=%h want=%h", n, {busy_b, busy_a, hex_b, hex_a}, f_expect());
      end else n_pass++;
    end
  endtask

  task automatic test_narrow();
    cycle(1, 0, 0, 0, 24'h0);
    cycle(0, 1, 1, 0, 24'h0002C7);
    n_chk++;
    if (hex_b !== {7'b1111111, GLYPH[2], GLYPH[12], GLYPH[7]}) begin
      $display("FAIL narrow_2C7 got=%h want=%h", hex_b, {7'b1111111, GLYPH[2], GLYPH[12], GLYPH[7]});
    end else n_pass++;
    n_chk++;
    if ({busy_b, busy_a, hex_b, hex_a} !== f_expect()) begin
      $display("FAIL narrow_model got=%h want=%h", {busy_b, busy_a, hex_b, hex_a}, f_expect());
    end else n_pass++;
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      cycle(r < 6, (r >= 6 && r < 20) || r == 99, $urandom_range(0, 1), r >= 96, 24'($urandom));
      n_chk++;
      if ({busy_b, busy_a, hex_b, hex_a} !== f_expect()) begin
        $display("FAIL random n=%0d got=%h want=%h", n, {busy_b, busy_a, hex_b, hex_a}, f_expect());
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_found();
    test_not_found();
    test_priority();
    test_narrow();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/key_hex_display.md
Name: key_hex_display

Overview:
- Multi-digit 7-segment controller for the key-search datapath.
- Tracks search progress and latches the reported key on completion.
- Drives NUM_DIGITS active-low hex digits with idle-blank, blinking "searching", found-key and not-found patterns.
- Sits between the search controller (start/done/key_valid/key) and the board HEX outputs, replacing per-digit combinational decoders.

Parameters:
- KEY_W, 24, key width in bits; digits used = ceil(KEY_W/4), must be <= NUM_DIGITS.
- NUM_DIGITS, 6, number of 7-segment digits driven.
- BLINK_DIV, 25000000, clock cycles per blink half-period in SEARCH; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse: key search has begun.
- done  input  1  single-cycle pulse: search finished; key/key_valid valid this cycle.
- key_valid  input  1  sampled with done: 1 = key found, 0 = no key exists.
- key  input  KEY_W  key value, sampled only on an accepted done.
- clear  input  1  return display to IDLE (blank).
- hex  output  NUM_DIGITS*7  digit i at hex[7*i+6:7*i]; digit 0 = least-significant nibble; bit 6 = seg g ... bit 0 = seg a; active-low.
- busy  output  1  high while in SEARCH.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, key register=0, blink counter=0, blink phase=0, hex=all 1s (blank), busy=0.
- States:
  - IDLE: all digits blank (7'b1111111).
  - SEARCH: all used digits show dash (7'b0111111) when blink phase=1, blank when phase=0; unused digits blank.
  - FOUND: used digits show hex glyphs of the latched key; unused digits blank.
  - FAIL: all used digits dash, steady; unused digits blank.
- Glyphs 0-F (g..a): 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Transitions:
  - Any state + start -> SEARCH; blink counter=0, phase=1.
  - SEARCH + done + key_valid -> FOUND; latch key.
  - SEARCH + done + !key_valid -> FAIL; key register unchanged.
  - Any state + clear -> IDLE.
  - done outside SEARCH is ignored.
- Priority when inputs coincide in one cycle: clear > start > done.
- Blink: counter counts 0..BLINK_DIV-1 in SEARCH only. At terminal count it wraps to 0 and toggles phase. Outside SEARCH it is held at 0.
- Latency: hex and busy are registered. They reflect the new state exactly 1 cycle after the triggering edge; no combinational input->output path.
- Width rules:
  - Used digits U = ceil(KEY_W/4).
  - If KEY_W is not a multiple of 4, the top nibble is zero-extended.
  - Leading-zero digits within U are shown as "0", not blanked.
- Reset mid-SEARCH: immediate blank, state IDLE; a subsequent done is ignored until a new start.
- start during FOUND/FAIL restarts SEARCH; the latched key is retained but not displayed.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> hex all 1s and busy=0 immediately; after release, hex stays all 1s.
- Blink (BLINK_DIV=4): start pulse -> next cycle busy=1, digits=0111111; toggles to blank after 4 cycles, back to dash after 8; continues with period 8.
- Found (KEY_W=24): start, then done with key_valid=1, key=24'h03A5F1 -> 1 cycle later digits 5..0 = 0,3,A,5,F,1 glyphs (digit 0 = 1111001); busy=0; later changes on key have no effect.
- Fail: start, then done with key_valid=0 -> all 6 digits 0111111 steady for more than 3*BLINK_DIV cycles.
- Priority and ignore:
  - done with key_valid=1 while IDLE -> hex stays blank.
  - start+done same cycle -> SEARCH.
  - clear+start same cycle -> IDLE.
- Narrow width (KEY_W=10, NUM_DIGITS=4): found key=10'h2C7 -> digits 2..0 = 2, C, 7; digit 3 blank.
